// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: state encodings,
// instruction size, queue depth and the queued {instruction, pc} payload.
package instruction_fetch_pkg;

    localparam int unsigned XLEN        = 64;
    localparam int unsigned ILEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;
    localparam int unsigned QUEUE_DEPTH = 2;
    localparam int unsigned OCC_W       = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned PTR_W       = $clog2(QUEUE_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        FAULT = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_queue.sv
// Two-entry FIFO of fetched {instruction, pc} pairs between fetch and decode.
// Flush beats push/pop; simultaneous push and pop leave occupancy unchanged.
module fetch_queue
    import instruction_fetch_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  fetch_entry_t     i_data,
    output fetch_entry_t     o_head,
    output logic [OCC_W-1:0] o_count
);

    fetch_entry_t     r_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [OCC_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push && (r_count != OCC_W'(QUEUE_DEPTH));
    assign w_pop  = i_pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + OCC_W'(1);
                2'b01:   r_count <= r_count - OCC_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: one outstanding memory request, 2-entry decode queue, redirects.
// Optional misaligned-redirect trap enabled by defining FETCH_ALIGN_CHECK_EN.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 64'h0
)
(
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [ILEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [ILEN-1:0] id_instruction,
    output logic [XLEN-1:0] id_pc,
    output logic            fetch_fault
);

    fetch_state_e     r_state;
    fetch_state_e     w_state_nxt;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  w_pc_nxt;
    logic [XLEN-1:0]  r_fetch_pc;
    logic [XLEN-1:0]  w_fetch_pc_nxt;
    logic             r_discard;
    logic             w_discard_nxt;
    logic             w_in_flight;
    logic [XLEN-1:0]  w_redirect_pc;
    logic             w_misaligned;
    logic             w_push;
    logic             w_pop;
    logic [OCC_W-1:0] w_count;
    logic [OCC_W-1:0] w_occ_after;
    fetch_entry_t     w_push_data;
    fetch_entry_t     w_head;

    assign w_redirect_pc = redirect_pc & ~XLEN'(INSTR_BYTES - 1);

`ifdef FETCH_ALIGN_CHECK_EN
    assign w_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign fetch_fault  = (r_state == FAULT);
`else
    assign w_misaligned = 1'b0;
    assign fetch_fault  = 1'b0;
`endif

    assign imem_req       = (r_state == REQ);
    assign imem_addr      = r_pc;
    assign id_valid       = (w_count != '0) && !redirect_valid;
    assign id_instruction = w_head.instr;
    assign id_pc          = w_head.pc;
    assign w_pop          = id_valid && id_ready;
    assign w_occ_after    = w_count + OCC_W'(1) - OCC_W'(w_pop);
    assign w_push_data    = '{instr: imem_rdata, pc: r_fetch_pc};

    // A response is still owed to us if it has not arrived by the end of this cycle.
    assign w_in_flight = ((r_state == WAIT) && !imem_rvalid)
                       || ((r_state == REQ) && imem_ready)
                       || (r_discard && !imem_rvalid);

    fetch_queue u_queue (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_data  (w_push_data),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // Next-state logic; a redirect overrides push, pop and new issue.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_fetch_pc_nxt = r_fetch_pc;
        w_discard_nxt  = r_discard;
        w_push         = 1'b0;

        if (imem_rvalid && r_discard) begin
            w_discard_nxt = 1'b0;
        end

        case (r_state)
            IDLE: begin
                if (redirect_valid) begin
                    w_pc_nxt = w_redirect_pc;
                    if (w_misaligned) w_state_nxt = FAULT;
                end else if ((w_count < OCC_W'(QUEUE_DEPTH)) && !r_discard) begin
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (imem_ready) begin
                    w_fetch_pc_nxt = r_pc;
                    w_pc_nxt       = r_pc + XLEN'(INSTR_BYTES);
                    w_state_nxt    = WAIT;
                end
                if (redirect_valid) begin
                    w_pc_nxt = w_redirect_pc;
                    if (imem_ready)   w_discard_nxt = 1'b1;
                    if (w_misaligned) w_state_nxt   = FAULT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    w_pc_nxt = w_redirect_pc;
                    if (imem_rvalid) begin
                        w_discard_nxt = 1'b0;
                        w_state_nxt   = w_misaligned ? FAULT : REQ;
                    end else begin
                        w_discard_nxt = 1'b1;
                        w_state_nxt   = w_misaligned ? FAULT : WAIT;
                    end
                end else if (imem_rvalid) begin
                    if (!r_discard) begin
                        w_push      = 1'b1;
                        w_state_nxt = (w_occ_after < OCC_W'(QUEUE_DEPTH)) ? REQ : IDLE;
                    end else begin
                        w_state_nxt = REQ;
                    end
                end
            end
            FAULT: begin
                if (redirect_valid && !w_misaligned) begin
                    w_pc_nxt    = w_redirect_pc;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_fetch_pc <= '0;
            r_discard  <= w_in_flight;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_discard  <= w_discard_nxt;
        end
    end

endmodule
